// File: rtl/csr_bus_pkg.sv
// Shared CSR bus definitions: operation codes, bus widths and the response record.
package csr_bus_pkg;

  localparam int CSR_ADDR_W = 12;
  localparam int CSR_DATA_W = 32;

  localparam logic [2:0] CSR_OP_READ  = 3'b000;
  localparam logic [2:0] CSR_OP_WRITE = 3'b001;
  localparam logic [2:0] CSR_OP_SET   = 3'b010;
  localparam logic [2:0] CSR_OP_CLEAR = 3'b011;

  typedef struct packed {
    logic                  err;
    logic [CSR_DATA_W-1:0] rdata;
  } csr_rsp_t;

  // Codes 1xx are reserved: issued as a plain read, reported as an error.
  function automatic logic csr_op_reserved(logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/csr_rsp_fifo.sv
// Synchronous FIFO with fall-through head; push and pop on a full FIFO in the same cycle are allowed.
module csr_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_i, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; only the pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/csr_bus_initiator.sv
// CSR bus initiator: request stream -> overlapped address/data phases -> response FIFO.
// Optional saturating error counter enabled by CSR_BUS_INITIATOR_ERRCNT_EN.
module csr_bus_initiator
  import csr_bus_pkg::*;
#(
  parameter int                    RSP_DEPTH = 4,
  parameter logic [CSR_ADDR_W-1:0] IDLE_ADDR = 12'h000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [CSR_ADDR_W-1:0] req_addr,
  input  logic [2:0]            req_op,
  input  logic [CSR_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [CSR_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [15:0]           err_count,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  output logic                  csr_read,
  output logic [2:0]            csr_modify,
  output logic [CSR_DATA_W-1:0] csr_wdata,
  input  logic [CSR_DATA_W-1:0] csr_rdata,
  input  logic                  csr_valid
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic                  accept, pop;
  logic [CNT_W-1:0]      out_q, out_d;
  logic                  ap_vld_q;
  logic [CSR_ADDR_W-1:0] csr_addr_q;
  logic [2:0]            ap_op_q;
  logic [CSR_DATA_W-1:0] ap_wdata_q;
  logic                  csr_read_q, dp_rsvd_q;
  logic [2:0]            csr_modify_q;
  logic [CSR_DATA_W-1:0] csr_wdata_q;
  logic                  rsp_push, rsp_full, rsp_empty;
  csr_rsp_t              push_rsp, head_rsp;

  assign accept    = req_valid & req_ready;
  assign pop       = rsp_valid & rsp_ready;
  assign req_ready = (out_q < CNT_W'(RSP_DEPTH));

  // Credits cover both in-flight phases and FIFO contents, so the FIFO never overflows.
  always_comb begin
    out_d = out_q;
    case ({accept, pop})
      2'b10:   out_d = out_q + CNT_W'(1);
      2'b01:   out_d = out_q - CNT_W'(1);
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) out_q <= '0;
    else       out_q <= out_d;
  end

  // Address phase
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ap_vld_q   <= 1'b0;
      csr_addr_q <= IDLE_ADDR;
    end else begin
      ap_vld_q   <= accept;
      csr_addr_q <= accept ? req_addr : IDLE_ADDR;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      ap_op_q    <= req_op;
      ap_wdata_q <= req_wdata;
    end
  end

  // Data phase
  always_ff @(posedge clk) begin
    if (!rstn) begin
      csr_read_q   <= 1'b0;
      dp_rsvd_q    <= 1'b0;
      csr_modify_q <= CSR_OP_READ;
      csr_wdata_q  <= '0;
    end else begin
      csr_read_q   <= ap_vld_q;
      dp_rsvd_q    <= ap_vld_q & csr_op_reserved(ap_op_q);
      csr_modify_q <= (ap_vld_q && !csr_op_reserved(ap_op_q)) ? ap_op_q : CSR_OP_READ;
      csr_wdata_q  <= ap_vld_q ? ap_wdata_q : '0;
    end
  end

  assign csr_addr   = csr_addr_q;
  assign csr_read   = csr_read_q;
  assign csr_modify = csr_modify_q;
  assign csr_wdata  = csr_wdata_q;

  // Response capture at the end of the data phase
  assign push_rsp.err   = ~csr_valid | dp_rsvd_q;
  assign push_rsp.rdata = csr_rdata;
  assign rsp_push       = csr_read_q & (~rsp_full | pop);

  csr_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH ($bits(csr_rsp_t))
  ) u_rsp_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (rsp_push),
    .wdata_i (push_rsp),
    .pop_i   (pop),
    .rdata_o (head_rsp),
    .full_o  (rsp_full),
    .empty_o (rsp_empty)
  );

  assign rsp_valid = ~rsp_empty;
  assign rsp_rdata = head_rsp.rdata;
  assign rsp_err   = head_rsp.err;

`ifdef CSR_BUS_INITIATOR_ERRCNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn)
      err_cnt_q <= '0;
    else if (rsp_push && push_rsp.err && (err_cnt_q != 16'hFFFF))
      err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_csr_bus_initiator.sv
// Directed bench for csr_bus_initiator with a pins register (0xbc1) and HARTID (0xf14) responder model.
module tb_csr_bus_initiator;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [11:0] req_addr = 12'h0;
  logic [2:0]  req_op = 3'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] err_count;
  logic [11:0] csr_addr;
  logic        csr_read;
  logic [2:0]  csr_modify;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_valid;

  always #5 clk = ~clk;

  csr_bus_initiator #(.RSP_DEPTH(4), .IDLE_ADDR(12'h000)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_op(req_op), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .err_count(err_count),
    .csr_addr(csr_addr), .csr_read(csr_read), .csr_modify(csr_modify),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_valid(csr_valid)
  );

  // Registered-decode responders: decode in the address phase, answer in the data phase.
  logic        tb_init = 1'b1;
  logic [31:0] pins_q;
  logic        dec_pins_q, dec_hart_q;

  always @(posedge clk) begin
    dec_pins_q <= (csr_addr == 12'hbc1);
    dec_hart_q <= (csr_addr == 12'hf14);
    if (tb_init) pins_q <= 32'h0;
    else if (csr_read && dec_pins_q) begin
      case (csr_modify)
        3'b001:  pins_q <= csr_wdata;
        3'b010:  pins_q <= pins_q | csr_wdata;
        3'b011:  pins_q <= pins_q & ~csr_wdata;
        default: pins_q <= pins_q;
      endcase
    end
  end

  assign csr_valid = csr_read & (dec_pins_q | dec_hart_q);
  assign csr_rdata = !csr_read ? 32'h0 : dec_pins_q ? pins_q : dec_hart_q ? 32'h3 : 32'h0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [11:0] log_addr [512];
  logic [2:0]  log_mod  [512];
  logic [31:0] log_wd   [512];
  logic        log_rd   [512];
  logic        log_rv   [512];

  always @(negedge clk) begin
    if (cyc < 512) begin
      log_addr[cyc] <= csr_addr;
      log_mod[cyc]  <= csr_modify;
      log_wd[cyc]   <= csr_wdata;
      log_rd[cyc]   <= csr_read;
      log_rv[cyc]   <= rsp_valid;
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;
  rsp_t rq[$];
  logic mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && rsp_valid && rsp_ready) rq.push_back('{err: rsp_err, rdata: rsp_rdata});
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [11:0] a, input logic [2:0] op, input logic [31:0] wd,
                      output int acc);
    bit ok;
    ok = 1'b0;
    acc = 0;
    req_addr = a; req_op = op; req_wdata = wd; req_valid = 1'b1;
    for (int w = 0; w < 50 && !ok; w++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc + 1;
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'(ok), 32'h1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_addr"},   32'(csr_addr), 32'h0);
    chk({tag, "_read"},   32'(csr_read), 32'h0);
    chk({tag, "_modify"}, 32'(csr_modify), 32'h0);
    chk({tag, "_wdata"},  csr_wdata, 32'h0);
    chk({tag, "_rspv"},   32'(rsp_valid), 32'h0);
    chk({tag, "_ready"},  32'(req_ready), 32'h1);
    chk({tag, "_errcnt"}, 32'(err_count), 32'h0);
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [2:0]  op;
    logic [31:0] wdata;
    logic [2:0]  exp_mod;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[10];
  int   acc[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_acc, a_rst, n_wr, exp_ec;

    vt[0] = '{12'hbc1, 3'b001, 32'h5,  3'b001, 1'b0, 32'h0};
    vt[1] = '{12'hbc1, 3'b000, 32'h0,  3'b000, 1'b0, 32'h5};
    vt[2] = '{12'hf14, 3'b000, 32'h0,  3'b000, 1'b0, 32'h3};
    vt[3] = '{12'hbc1, 3'b010, 32'hA,  3'b010, 1'b0, 32'h5};
    vt[4] = '{12'hbc1, 3'b000, 32'h0,  3'b000, 1'b0, 32'hF};
    vt[5] = '{12'h123, 3'b000, 32'h0,  3'b000, 1'b1, 32'h0};
    vt[6] = '{12'hbc1, 3'b101, 32'hFF, 3'b000, 1'b1, 32'hF};
    vt[7] = '{12'hbc1, 3'b011, 32'h3,  3'b011, 1'b0, 32'hF};
    vt[8] = '{12'hbc1, 3'b000, 32'h0,  3'b000, 1'b0, 32'hC};
    vt[9] = '{12'hf14, 3'b001, 32'h7,  3'b001, 1'b0, 32'h3};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk); #1;
    rstn = 1'b1; tb_init = 1'b0;
    @(posedge clk); #1;

    // Back-to-back table with the response side always ready
    rsp_ready = 1'b1; mon_en = 1'b1;
    for (int i = 0; i < 10; i++) send(vt[i].addr, vt[i].op, vt[i].wdata, acc[i]);
    repeat (8) @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      chk($sformatf("v%0d_addr_phase", i), 32'(log_addr[acc[i]]), 32'(vt[i].addr));
      chk($sformatf("v%0d_modify", i), 32'(log_mod[acc[i] + 1]), 32'(vt[i].exp_mod));
      chk($sformatf("v%0d_read", i), 32'(log_rd[acc[i] + 1]), 32'h1);
      if (i > 0) chk($sformatf("v%0d_back_to_back", i), 32'(acc[i]), 32'(acc[i-1] + 1));
    end
    chk("v0_wdata", log_wd[acc[0] + 1], 32'h5);
    chk("v0_rspv_early", 32'(log_rv[acc[0] + 1]), 32'h0);
    chk("v0_rspv_k2", 32'(log_rv[acc[0] + 2]), 32'h1);
    chk("idle_addr_after", 32'(log_addr[acc[9] + 1]), 32'h0);
    chk("idle_mod_after", 32'(log_mod[acc[9] + 2]), 32'h0);
    chk("table_rsp_count", 32'(rq.size()), 32'd10);
    for (int i = 0; i < 10 && i < rq.size(); i++) begin
      chk($sformatf("v%0d_rdata", i), rq[i].rdata, vt[i].exp_rdata);
      chk($sformatf("v%0d_err", i), 32'(rq[i].err), 32'(vt[i].exp_err));
    end
`ifdef CSR_BUS_INITIATOR_ERRCNT_EN
    exp_ec = 2;
`else
    exp_ec = 0;
`endif
    chk("err_count_table", 32'(err_count), 32'(exp_ec));

    // Backpressure: four credits, then exactly one more after a single pop
    rq.delete();
    rsp_ready = 1'b0;
    req_addr = 12'hbc1; req_op = 3'b000; req_wdata = 32'h0; req_valid = 1'b1;
    n_acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_ready) n_acc++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("bp_accepts", 32'(n_acc), 32'd4);
    chk("bp_ready_low", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (req_ready) n_acc++;
      @(posedge clk); #1;
    end
    chk("bp_one_more", 32'(n_acc), 32'd1);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_rsp_count", 32'(rq.size()), 32'd5);
    for (int i = 0; i < rq.size(); i++) begin
      chk($sformatf("bp%0d_rdata", i), rq[i].rdata, 32'hC);
      chk($sformatf("bp%0d_err", i), 32'(rq[i].err), 32'h0);
    end

    // Reset during the address phase of a write
    rq.delete();
    send(12'hbc1, 3'b001, 32'h77, a_rst);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk_reset_state("midreset");
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("rst_addr_phase_seen", 32'(log_addr[a_rst]), 32'hbc1);
    n_wr = 0;
    for (int c = a_rst; c < a_rst + 7; c++) if (log_mod[c] == 3'b001) n_wr++;
    chk("rst_no_write_strobe", 32'(n_wr), 32'd0);
    chk("rst_pins_unchanged", pins_q, 32'hC);
    chk("rst_no_response", 32'(rq.size()), 32'd0);
    chk("rst_rspv", 32'(rsp_valid), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h1);

`ifdef CSR_BUS_INITIATOR_ERRCNT_EN
    // Saturation: stream unmapped reads past 16 bits of error count
    mon_en = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_addr = 12'h123; req_op = 3'b000; req_valid = 1'b1;
    repeat (65545) @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("err_count_saturate", 32'(err_count), 32'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
